// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - forwarding, stall/flush and data-memory wait control for the 5-stage pipeline
module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [4:0]       RsD,
   input  logic [4:0]       RtD,
   input  logic [4:0]       RsE,
   input  logic [4:0]       RtE,
   input  logic [4:0]       WriteRegE,
   input  logic [4:0]       WriteRegM,
   input  logic [4:0]       WriteRegW,
   input  logic             RegWriteE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic             MemtoRegE,
   input  logic             MemtoRegM,
   input  logic             BranchD,
   input  logic             TakenD,
   input  logic             MemReqM,
   input  logic             MemReady,
   output logic [1:0]       ForwardAE,
   output logic [1:0]       ForwardBE,
   output logic             ForwardAD,
   output logic             ForwardBD,
   output logic             StallF,
   output logic             StallD,
   output logic             StallE,
   output logic             StallM,
   output logic             FlushD,
   output logic             FlushE,
   output logic             FlushW,
   output logic             MemErr,
   output logic [CNT_W-1:0] StallCnt
);

   localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

   typedef enum logic {IDLE = 1'b0, MEMWAIT = 1'b1} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [WAIT_W-1:0] wait_cnt;
   logic [CNT_W-1:0]  stall_cnt;
   logic              mem_hold;
   logic              timeout;
   logic              lwstall;
   logic              brstall;

   function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic [4:0] wr_m,
                                          input logic [4:0] wr_w, input logic we_m,
                                          input logic we_w);
      if (src != 5'd0 && src == wr_m && we_m)
         return 2'b10;
      else if (src != 5'd0 && src == wr_w && we_w)
         return 2'b01;
      else
         return 2'b00;
   endfunction

   function automatic logic reads(input logic [4:0] dst, input logic [4:0] rs,
                                  input logic [4:0] rt);
      return (dst != 5'd0) && ((dst == rs) || (dst == rt));
   endfunction

   assign lwstall = MemtoRegE && RegWriteE && reads(WriteRegE, RsD, RtD);
   assign brstall = BranchD && ((RegWriteE && reads(WriteRegE, RsD, RtD)) ||
                                (MemtoRegM && RegWriteM && reads(WriteRegM, RsD, RtD)));
   assign timeout = (state == MEMWAIT) && !MemReady && (wait_cnt == WAIT_MAX);

   // mem_hold is the freeze condition for this cycle; the MemReady/timeout cycle releases
   always_comb begin
      mem_hold  = 1'b0;
      state_nxt = state;
      case (state)
         IDLE: begin
            mem_hold = MemReqM && !MemReady;
            if (mem_hold)
               state_nxt = MEMWAIT;
         end
         MEMWAIT: begin
            mem_hold = !MemReady && (wait_cnt != WAIT_MAX);
            if (!mem_hold)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      ForwardAD = 1'b0;
      ForwardBD = 1'b0;
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushW    = 1'b0;
      MemErr    = 1'b0;
      if (!rst_n) begin
         FlushD = 1'b1;
         FlushE = 1'b1;
         FlushW = 1'b1;
      end else begin
         ForwardAE = fwd_sel(RsE, WriteRegM, WriteRegW, RegWriteM, RegWriteW);
         ForwardBE = fwd_sel(RtE, WriteRegM, WriteRegW, RegWriteM, RegWriteW);
         ForwardAD = (RsD != 5'd0) && (RsD == WriteRegM) && RegWriteM;
         ForwardBD = (RtD != 5'd0) && (RtD == WriteRegM) && RegWriteM;
         MemErr    = timeout;
         if (mem_hold) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
         end else if (lwstall || brstall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            FlushE = 1'b1;
         end else begin
            FlushD = TakenD;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         state <= state_nxt;
         if (state == IDLE)
            wait_cnt <= '0;
         else if (mem_hold)
            wait_cnt <= wait_cnt + WAIT_W'(1);
         if (StallF && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   assign StallCnt = stall_cnt;

endmodule
